sample_stream_pacer: RTL
========================

// Module: sample_stream_pacer
// PURPOSE
//  Upstream sample source for the delta-sigma PWM modulator. Buffers 16-bit samples written by the host
//  (already assembled from byte pairs by the top-level register interface) in a small FIFO.
//  Releases one sample per N modulator pulses, paced by pulse_done, so the host can stream audio
//  asynchronously. The released sample drives the modulator input register (u16) via sample_update.
// PARAMETERS
//  WIDTH        16      sample width, bits
//  DEPTH_LOG2   2       log2 of FIFO depth (default 4 entries)
//  DIV_BITS     6       width of pulse divider
//  RESET_SAMPLE 16'h2000 sample_out value after reset (mid-scale, 1 << (FRAC_BITS-1))
// PORTS
//  clk           in   1           clock
//  reset         in   1           synchronous, active-high reset
//  wr_en         in   1           push strobe, one cycle per sample
//  wr_data       in   WIDTH       sample to push
//  enable        in   1           1 = pacing runs; 0 = divider frozen, no pops
//  divider       in   DIV_BITS    pulses per sample minus 1 (0 = one sample per pulse)
//  pulse_done    in   1           one-cycle strobe from modulator at end of each PWM pulse
//  flush         in   1           empty FIFO, restart divider
//  clear_flags   in   1           clear sticky underrun/overrun
//  sample_out    out  WIDTH       last released sample (held between releases)
//  sample_update out  1           one-cycle strobe: sample_out changed this cycle
//  fill_level    out  DEPTH_LOG2+1  entries currently stored (0..2**DEPTH_LOG2)
//  full          out  1           fill_level == 2**DEPTH_LOG2
//  underrun      out  1           sticky: tick occurred with FIFO empty
//  overrun       out  1           sticky: push dropped because FIFO full
// BEHAVIOUR
//  Reset: sample_out=RESET_SAMPLE, sample_update=0, fill_level=0, full=0, underrun=0, overrun=0,
//   divider counter=0, read/write pointers=0. Reset mid-operation discards all stored samples.
//  Divider: counter cnt (DIV_BITS). When enable & pulse_done: if cnt==0 -> tick, cnt<=divider;
//   else cnt<=cnt-1. enable=0 holds cnt, no ticks. divider changes take effect at next reload.
//  Tick, FIFO non-empty: pop head; sample_out<=head and sample_update=1 in the cycle after the tick
//   (latency 1); sample_update is registered and low in all other cycles.
//  Tick, FIFO empty: no pop, sample_out holds, underrun<=1, sample_update stays 0.
//  Push: wr_en accepted if !full, or if a pop happens the same cycle (the freed slot is reused).
//   A rejected push is dropped and sets overrun<=1; FIFO contents are unchanged.
//  Simultaneous push+pop: fill_level unchanged; pop returns the old head (no bypass).
//  Push while empty and tick in the same cycle: tick sees empty -> underrun; pushed word is stored.
//  Pointers: DEPTH_LOG2 bits, wrap modulo depth; fill_level tracked separately (or via an extra pointer
//   bit); full/empty are derived from fill_level only.
//  flush (priority over push/pop in the same cycle): pointers and fill_level <= 0, cnt <= 0;
//   sample_out, underrun, and overrun are held. A wr_en in a flush cycle is discarded; no flag is set.
//  clear_flags: both sticky flags <= 0, unless a new underrun/overrun event occurs the same cycle
//   (the event wins).
//  All outputs are registered except full, which is decoded from the fill_level register.
// TESTING
//  1 Reset, then check idle outputs -> sample_out=16'h2000, fill_level=0, flags 0, no sample_update.
//  2 divider=2, enable=1, push 16'h1111,16'h2222; issue 6 pulse_done -> releases on 1st and 4th pulse;
//    sample_out=1111 then 2222; each sample_update lasts 1 cycle, 1 cycle after its tick.
//  3 Push 5 words 1..5 with no ticks -> fill_level=4, full=1, overrun=1; pops return 1,2,3,4.
//  4 FIFO empty, divider=0: pulse_done -> underrun=1, sample_out holds; clear_flags -> underrun=0.
//  5 FIFO full, wr_en=16'hAAAA and tick in the same cycle -> no overrun, fill_level stays 4,
//    AAAA is popped last.
//  6 With 3 stored words: assert flush during a pulse_done and a wr_en -> fill_level=0, no
//    sample_update; a subsequent tick -> underrun=1.

Source files
------------

// File: rtl/sample_stream_pacer.sv
// Sample FIFO feeding the PWM modulator input register: releases one buffered sample
// every (divider+1) modulator pulses, with sticky underrun/overrun reporting.
module sample_stream_pacer #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH_LOG2   = 2,
  parameter int               DIV_BITS     = 6,
  parameter logic [WIDTH-1:0] RESET_SAMPLE = 'h2000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  enable,
  input  logic [DIV_BITS-1:0]   divider,
  input  logic                  pulse_done,
  input  logic                  flush,
  input  logic                  clear_flags,
  output logic [WIDTH-1:0]      sample_out,
  output logic                  sample_update,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  full,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DIV_BITS-1:0]   cnt;

  logic empty;
  logic tick;
  logic pop;
  logic push;
  logic underrun_evt;
  logic overrun_evt;

  // Flush overrides everything in its cycle: no tick, no pop, no push and no flag events.
  assign full         = (fill_level == FULL_LEVEL);
  assign empty        = (fill_level == '0);
  assign tick         = enable && pulse_done && (cnt == '0) && !flush;
  assign pop          = tick && !empty;
  assign push         = wr_en && !flush && (!full || pop);
  assign underrun_evt = tick && empty;
  assign overrun_evt  = wr_en && !flush && full && !pop;

  // Storage needs no reset; fill_level alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fill_level    <= '0;
      sample_out    <= RESET_SAMPLE;
      sample_update <= 1'b0;
      underrun      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sample_update <= pop;
      if (pop) sample_out <= mem[rd_ptr];

      if (flush) begin
        cnt        <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fill_level <= '0;
      end else begin
        if (enable && pulse_done) cnt <= (cnt == '0) ? divider : cnt - 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fill_level <= fill_level + 1'b1;
          2'b01:   fill_level <= fill_level - 1'b1;
          default: fill_level <= fill_level;
        endcase
      end

      // A new event in the same cycle as clear_flags keeps the flag set.
      if (underrun_evt)     underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
      if (overrun_evt)      overrun  <= 1'b1;
      else if (clear_flags) overrun  <= 1'b0;
    end
  end

endmodule
